// File: rtl/sync_fifo_ft.sv
// sync_fifo_ft: single-clock FIFO.
// - Read mode is selectable: standard (registered read data) or
//   first-word-fall-through.
// - Almost-full and almost-empty thresholds are set by parameters.
// - Overflow and underflow are sticky error flags.
// - A synchronous flush clears the contents and the flags.
// - A high-water-mark counter records the peak fill level.
//
// Ports:
//   i_clk, i_rst          clock; synchronous active-high reset
//   i_flush               synchronous clear of pointers, count and flags
//   i_wr_en, i_wr_data    write request and data
//   o_full, o_almost_full, o_overflow       write-side status
//   i_rd_en               read request (pop of the head word in FWFT mode)
//   o_rd_data, o_rd_valid read data and its valid indication
//   o_empty, o_almost_empty, o_underflow    read-side status
//   o_data_count          words stored, 0..DEPTH
//   o_max_count           highest o_data_count since reset or flush
module sync_fifo_ft #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 16,
    parameter int FWFT       = 0,
    parameter int AF_LEVEL   = DEPTH - 1,
    parameter int AE_LEVEL   = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_flush,
    input  logic                         i_wr_en,
    input  logic [DATA_WIDTH-1:0]        i_wr_data,
    output logic                         o_full,
    output logic                         o_almost_full,
    output logic                         o_overflow,
    input  logic                         i_rd_en,
    output logic [DATA_WIDTH-1:0]        o_rd_data,
    output logic                         o_rd_valid,
    output logic                         o_empty,
    output logic                         o_almost_empty,
    output logic                         o_underflow,
    output logic [$clog2(DEPTH):0]       o_data_count,
    output logic [$clog2(DEPTH):0]       o_max_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_nxt;
    logic [CW-1:0]         max_count;
    logic                  full;
    logic                  almost_full;
    logic                  empty;
    logic                  almost_empty;
    logic                  overflow;
    logic                  underflow;
    logic                  rd_ok;
    logic                  wr_ok;

    function automatic logic af_of(input logic [CW-1:0] cnt);
        return cnt >= CW'(AF_LEVEL);
    endfunction

    function automatic logic ae_of(input logic [CW-1:0] cnt);
        return cnt <= CW'(AE_LEVEL);
    endfunction

    // A full FIFO still accepts a write when a read frees a slot in the same cycle.
    always_comb begin
        rd_ok     = i_rd_en & ~empty;
        wr_ok     = i_wr_en & (~full | rd_ok);
        count_nxt = count;
        if (wr_ok && !rd_ok) begin
            count_nxt = count + CW'(1);
        end else if (rd_ok && !wr_ok) begin
            count_nxt = count - CW'(1);
        end
    end

    // The status flags are registered from count_nxt.
    // They therefore line up with o_data_count in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            max_count    <= '0;
            full         <= 1'b0;
            almost_full  <= af_of('0);
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count        <= count_nxt;
            full         <= (count_nxt == CW'(DEPTH));
            almost_full  <= af_of(count_nxt);
            empty        <= (count_nxt == '0);
            almost_empty <= ae_of(count_nxt);
            if (i_wr_en && !wr_ok) begin
                overflow <= 1'b1;
            end
            if (i_rd_en && empty) begin
                underflow <= 1'b1;
            end
            if (count_nxt > max_count) begin
                max_count <= count_nxt;
            end
        end
    end

    // Storage is never cleared; only the pointers define what is valid.
    always_ff @(posedge i_clk) begin
        if (!i_rst && !i_flush && wr_ok) begin
            mem[wr_ptr] <= i_wr_data;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // The head word is presented combinationally whenever the FIFO is non-empty.
            assign o_rd_data  = mem[rd_ptr];
            assign o_rd_valid = ~empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] rd_data_p1;
            logic                  vld_p1;

            // Read stage: the data and the valid pulse appear one edge after rd_ok.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    rd_data_p1 <= '0;
                    vld_p1     <= 1'b0;
                end else if (i_flush) begin
                    vld_p1 <= 1'b0;
                end else begin
                    vld_p1 <= rd_ok;
                    if (rd_ok) begin
                        rd_data_p1 <= mem[rd_ptr];
                    end
                end
            end

            assign o_rd_data  = rd_data_p1;
            assign o_rd_valid = vld_p1;
        end
    endgenerate

    assign o_full         = full;
    assign o_almost_full  = almost_full;
    assign o_overflow     = overflow;
    assign o_empty        = empty;
    assign o_almost_empty = almost_empty;
    assign o_underflow    = underflow;
    assign o_data_count   = count;
    assign o_max_count    = max_count;

endmodule

// File: tb/tb_sync_fifo_ft.sv
// Testbench for sync_fifo_ft.
// Two instances are driven with identical stimulus: one in standard read
// mode and one in first-word-fall-through mode. Both use DEPTH=4,
// AF_LEVEL=3 and AE_LEVEL=1. A queue model holds the expected contents and
// status of the FIFO, and it is compared with both instances every cycle.
module tb_sync_fifo_ft;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int AE    = 1;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;

    logic          s_full, s_afull, s_ovf, s_rd_valid, s_empty, s_aempty, s_udf;
    logic [DW-1:0] s_rd_data;
    logic [CW-1:0] s_count, s_max;

    logic          f_full, f_afull, f_ovf, f_rd_valid, f_empty, f_aempty, f_udf;
    logic [DW-1:0] f_rd_data;
    logic [CW-1:0] f_count, f_max;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] mq [$];
    bit            movf = 0;
    bit            mudf = 0;
    int            mmax = 0;

    always #5 clk = ~clk;

    sync_fifo_ft #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_std (
        .i_clk(clk), .i_rst(rst), .i_flush(flush),
        .i_wr_en(wr_en), .i_wr_data(wr_data),
        .o_full(s_full), .o_almost_full(s_afull), .o_overflow(s_ovf),
        .i_rd_en(rd_en), .o_rd_data(s_rd_data), .o_rd_valid(s_rd_valid),
        .o_empty(s_empty), .o_almost_empty(s_aempty), .o_underflow(s_udf),
        .o_data_count(s_count), .o_max_count(s_max)
    );

    sync_fifo_ft #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_fwft (
        .i_clk(clk), .i_rst(rst), .i_flush(flush),
        .i_wr_en(wr_en), .i_wr_data(wr_data),
        .o_full(f_full), .o_almost_full(f_afull), .o_overflow(f_ovf),
        .i_rd_en(rd_en), .o_rd_data(f_rd_data), .o_rd_valid(f_rd_valid),
        .o_empty(f_empty), .o_almost_empty(f_aempty), .o_underflow(f_udf),
        .o_data_count(f_count), .o_max_count(f_max)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Runs one clock: drives the inputs, advances the model, then checks both instances.
    task automatic step(input bit wr, input logic [DW-1:0] d, input bit rd,
                        input bit fl, input bit rs);
        bit            rdok;
        bit            wrok;
        logic [DW-1:0] exp_rd;
        int            n;
        exp_rd = '0;
        n      = mq.size();
        rdok   = rd && (n != 0);
        wrok   = wr && ((n != DEPTH) || rdok);
        wr_en   = wr;
        wr_data = d;
        rd_en   = rd;
        flush   = fl;
        rst     = rs;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        flush = 1'b0;
        rst   = 1'b0;
        if (rs || fl) begin
            mq.delete();
            movf = 0;
            mudf = 0;
            mmax = 0;
            rdok = 0;
        end else begin
            if (rd && n == 0) mudf = 1;
            if (wr && !wrok) movf = 1;
            if (rdok) exp_rd = mq.pop_front();
            if (wrok) mq.push_back(d);
            if (mq.size() > mmax) mmax = mq.size();
        end
        n = mq.size();
        chk("rd_valid", 64'(s_rd_valid), 64'(rdok));
        if (rdok) chk("rd_data", 64'(s_rd_data), 64'(exp_rd));
        if (rs) chk("rst_rd_data", 64'(s_rd_data), 64'd0);
        chk("count", 64'(s_count), 64'(n));
        chk("empty", 64'(s_empty), 64'(n == 0));
        chk("full", 64'(s_full), 64'(n == DEPTH));
        chk("afull", 64'(s_afull), 64'(n >= AF));
        chk("aempty", 64'(s_aempty), 64'(n <= AE));
        chk("overflow", 64'(s_ovf), 64'(movf));
        chk("underflow", 64'(s_udf), 64'(mudf));
        chk("max_count", 64'(s_max), 64'(mmax));
        chk("ff_count", 64'(f_count), 64'(n));
        chk("ff_empty", 64'(f_empty), 64'(n == 0));
        chk("ff_valid", 64'(f_rd_valid), 64'(n != 0));
        if (n != 0) chk("ff_data", 64'(f_rd_data), 64'(mq[0]));
        chk("ff_ovf", 64'(f_ovf), 64'(movf));
        chk("ff_udf", 64'(f_udf), 64'(mudf));
        chk("ff_max", 64'(f_max), 64'(mmax));
    endtask

    task automatic wr1(input logic [DW-1:0] d);
        step(1, d, 0, 0, 0);
    endtask

    task automatic rd1();
        step(0, '0, 1, 0, 0);
    endtask

    task automatic idle();
        step(0, '0, 0, 0, 0);
    endtask

    initial begin
        // Reset, then idle.
        step(0, '0, 0, 0, 1);
        step(1, 32'h1234, 1, 0, 1);
        idle();

        // Fill, overflow, drain with isolated read pulses.
        for (int i = 1; i <= 4; i++) wr1(32'(i));
        wr1(32'hDEADBEEF);
        for (int i = 0; i < 4; i++) begin
            rd1();
            idle();
        end

        // Simultaneous write and read while full.
        step(0, '0, 0, 1, 0);
        for (int i = 1; i <= 4; i++) wr1(32'(i));
        step(1, 32'hAAAA, 1, 0, 0);
        for (int i = 0; i < 4; i++) rd1();
        idle();

        // Read and write together while empty.
        step(1, 32'h55, 1, 0, 0);
        rd1();
        idle();

        // Threshold flags.
        step(0, '0, 0, 1, 0);
        for (int i = 0; i < 3; i++) wr1(32'h100 + 32'(i));
        rd1();
        rd1();
        idle();

        // Flush with a concurrent write, starting from count 3 with overflow set.
        step(0, '0, 0, 1, 0);
        for (int i = 0; i < 5; i++) wr1(32'h200 + 32'(i));
        rd1();
        step(1, 32'h99, 1, 1, 0);
        wr1(32'h77);
        rd1();
        idle();

        // Mid-stream reset with a concurrent write, same starting state.
        for (int i = 0; i < 5; i++) wr1(32'h300 + 32'(i));
        rd1();
        step(1, 32'h98, 1, 0, 1);
        wr1(32'h66);
        rd1();
        idle();

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            step(bit'($urandom_range(0, 1)), $urandom, bit'($urandom_range(0, 1)),
                 ($urandom_range(0, 39) == 0), 1'b0);
        end
        for (int i = 0; i < DEPTH + 1; i++) rd1();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
